sequence_line_extractor: RTL
============================

# sequence_line_extractor

Receive-side counterpart of the sequence injection stage. The block watches the decoded BT.656 stream and its H/V flags, and captures the key-sequence line carried in the first active line after vertical blanking. From that line it extracts a 32-bit seed, checks it for redundancy errors and hands it to the descrambler's generator. It also blanks that line to black and holds `V_out` high across it, so the downstream line rotator passes the line through without descrambling.

## Interface
Parameters:
- `ACTIVE_VIDEO_PIXELS`, 1440: 10-bit words per active line (2 × 720).
- `SEED_WORDS`, 4: number of words carrying the seed. The seed width is 8 × `SEED_WORDS`.
- `BLANK_LINE`, 1: when 1, the captured line is replaced by black on the output. When 0, it passes through unchanged.

Ports:
- `clk` in 1: system clock, one domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `H` in 1: horizontal blanking flag. High = blanking, low = active video.
- `V` in 1: vertical blanking flag. High = blanking.
- `bt656_stream_in` in 10: decoded BT.656 words.
- `bt656_stream_out` out 10: stream with the sequence line optionally blanked. Registered.
- `V_out` out 1: `V` OR'ed with the internal "sequence line" flag. Registered.
- `seed` out 32: last successfully extracted seed. Holds its value between frames.
- `seed_valid` out 1: one-cycle pulse when `seed` has just been updated.
- `seed_error` out 1: one-cycle pulse when a line was captured but failed its check or was aborted.

## Operation
- Edge detection uses registered `prev_H` and `prev_V`:
  - `H_fall = prev_H & !H`
  - `V_fall = prev_V & !V`
  - `V_rise = !prev_V & V`
- FSM states and transitions:
  - **IDLE**: on `V_fall` → ARMED.
  - **ARMED**: on the first `H_fall` → CAPTURE, with `pixel_cnt` = 0 in that cycle. On `V_rise` → IDLE.
  - **CAPTURE**: while `H` is low, `pixel_cnt` increments every cycle. The word present in a cycle has index `pixel_cnt`.
    - When `pixel_cnt` = `ACTIVE_VIDEO_PIXELS`−1 → DONE.
    - If `H` rises or `V` rises before that point, the line is aborted: `seed_error` pulses and the FSM returns to IDLE.
  - **DONE**: waits for `V` high → IDLE. No further capture occurs in the same field.
- Seed extraction:
  - Words 0..3: shift register `seed_sh <= {seed_sh[23:0], din[9:2]}`. Word 0 ends up in bits [31:24].
  - Words 4..7: `din[9:2]` is compared against byte (idx−4) of `seed_sh`. Any mismatch sets a sticky `mismatch` flag, which is cleared on entry to CAPTURE.
- End of line, at the cycle after the last word:
  - If `mismatch` = 0: `seed <= seed_sh` and `seed_valid` pulses.
  - Otherwise: `seed` is unchanged and `seed_error` pulses.
- Internal flag `V_int`: set on entry to CAPTURE, cleared on entry to DONE or on abort.
- Blanking, when `BLANK_LINE`=1: for every CAPTURE word, the output is 10'h200 for even indices and 10'h040 for odd indices (Cb/Y/Cr/Y black).

## Timing
- `bt656_stream_out` and `V_out` have a fixed latency of 1 cycle from their inputs. The blanking decision is aligned with the data it replaces.
- `seed` and `seed_valid` update 1 cycle after the word with index 1439 is sampled.
- `seed_error` pulses:
  - 1 cycle after the word with index 1439 is sampled (mismatch case), or
  - 1 cycle after the abort edge is sampled.
- Reset values:
  - `bt656_stream_out` = 0, `V_out` = 0, `seed` = 0, `seed_valid` = 0, `seed_error` = 0.
  - FSM = IDLE, `pixel_cnt` = 0.
  - `prev_H` / `prev_V` load `H` / `V`, so no false edge is seen after reset.
- Reset asserted mid-CAPTURE aborts silently: no error pulse. Capture resumes only after the next `V_fall`.
- If `H_fall` and `V_fall` occur in the same cycle, the FSM enters ARMED only. The line starts at the next `H_fall`.
- `pixel_cnt` is $clog2(`ACTIVE_VIDEO_PIXELS`) bits wide and never wraps. It saturates at DONE.

## Structure
- Shared package `seq_pkg`:
  - `ACTIVE_VIDEO_PIXELS`
  - `BLACK_C` = 10'h200 and `BLACK_Y` = 10'h040
  - `SEED_WORDS`
  - FSM state encoding `seq_rx_state_t` with values IDLE, ARMED, CAPTURE, DONE
- The injection side imports the same package.
- One sub-module: `hv_edge_detect`. It holds the prev registers and produces the `H_fall`, `V_fall` and `V_rise` strobes, and is reusable by the injector.

## Test plan
- **Clean capture**: `V` falls, then `H` falls. Line words are 0x124, 0x348, 0x25C, 0x170, followed by the same four words, followed by filler.
  - Expect `seed_valid` pulse with `seed` = 0x49D2_975C.
  - Expect output = 0x200/0x040 black for all 1440 words.
  - Expect `V_out` high for the whole line.
- **Mismatch**: same as above, but word 6 = 0x000.
  - Expect a `seed_error` pulse.
  - Expect `seed` to keep its previous value and no `seed_valid`.
- **Early abort**: `H` rises at index 700.
  - Expect `seed_error` 1 cycle later.
  - Expect FSM in IDLE.
  - Expect the next line to pass through unblanked with `V_out` low.
- **Only one line per field**: after a valid capture, present a second active line.
  - Expect it to pass through unchanged.
  - Expect no pulses until the next field.
- **Reset mid-CAPTURE**: assert `reset_n` low at index 300.
  - Expect all outputs 0.
  - After release, expect no capture until a fresh `V_fall` followed by `H_fall`.
- **`BLANK_LINE`=0**: run the clean-capture stimulus.
  - Expect output = input delayed by 1 cycle.
  - Expect the seed still extracted.

Source files
------------

// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Constants and types shared by the key-sequence injector and extractor.
//   ACTIVE_VIDEO_PIXELS : 10-bit words per active line (2 x 720)
//   SEED_WORDS          : words carrying the seed (seed is 8 x SEED_WORDS bits)
//   BLACK_C / BLACK_Y   : black chroma / luma code words
//   seq_rx_state_t      : extractor FSM states
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int unsigned ACTIVE_VIDEO_PIXELS = 1440;
    localparam int unsigned SEED_WORDS          = 4;

    localparam logic [9:0] BLACK_C = 10'h200;
    localparam logic [9:0] BLACK_Y = 10'h040;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } seq_rx_state_t;

    // Cb/Y/Cr/Y ordering: even words are chroma, odd words are luma.
    function automatic logic [9:0] black_word(input logic odd);
        return odd ? BLACK_Y : BLACK_C;
    endfunction

endpackage

// File: rtl/hv_edge_detect.sv
// ---------------------------------------------------------------------------
// hv_edge_detect
// Registers the previous H/V flags and produces single-cycle edge strobes.
// Ports:
//   clk    in  : system clock
//   H, V   in  : horizontal / vertical blanking flags (high = blanking)
//   h_fall out : prev_H & !H
//   v_fall out : prev_V & !V
//   v_rise out : !prev_V & V
// ---------------------------------------------------------------------------
module hv_edge_detect (
    input  logic clk,
    input  logic H,
    input  logic V,
    output logic h_fall,
    output logic v_fall,
    output logic v_rise
);

    logic prev_h_q;
    logic prev_v_q;

    // No reset on purpose: with the clock running these keep following H/V
    // while the rest of the design is held in reset, so no false edge is
    // seen on the first cycle after release.
    always_ff @(posedge clk) begin
        prev_h_q <= H;
        prev_v_q <= V;
    end

    assign h_fall = prev_h_q & ~H;
    assign v_fall = prev_v_q & ~V;
    assign v_rise = ~prev_v_q & V;

endmodule

// File: rtl/sequence_line_extractor.sv
// ---------------------------------------------------------------------------
// sequence_line_extractor
// Captures the key-sequence line (first active line after vertical blanking),
// extracts and redundancy-checks the seed, and optionally blanks that line
// while holding V_out high across it so the line rotator leaves it alone.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   H, V              : horizontal / vertical blanking flags
//   bt656_stream_in   : decoded BT.656 words
//   bt656_stream_out  : stream with the sequence line optionally blanked (1-cycle latency)
//   V_out             : V OR sequence-line flag (1-cycle latency)
//   seed              : last successfully extracted seed
//   seed_valid        : one-cycle pulse when seed updates
//   seed_error        : one-cycle pulse on check failure or aborted line
// ---------------------------------------------------------------------------
module sequence_line_extractor #(
    parameter int unsigned ACTIVE_VIDEO_PIXELS = seq_pkg::ACTIVE_VIDEO_PIXELS,
    parameter int unsigned SEED_WORDS          = seq_pkg::SEED_WORDS,
    parameter bit          BLANK_LINE          = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    H,
    input  logic                    V,
    input  logic [9:0]              bt656_stream_in,
    output logic [9:0]              bt656_stream_out,
    output logic                    V_out,
    output logic [8*SEED_WORDS-1:0] seed,
    output logic                    seed_valid,
    output logic                    seed_error
);

    import seq_pkg::*;

    localparam int unsigned SEED_BITS = 8 * SEED_WORDS;
    localparam int unsigned CNT_W     = $clog2(ACTIVE_VIDEO_PIXELS);
    localparam int unsigned SW_W      = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;

    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(ACTIVE_VIDEO_PIXELS - 1);
    localparam logic [CNT_W-1:0] SEED_END  = CNT_W'(SEED_WORDS);
    localparam logic [CNT_W-1:0] CHECK_END = CNT_W'(2 * SEED_WORDS);

    seq_rx_state_t        state_q;
    logic [CNT_W-1:0]     pixel_cnt_q;
    logic [SEED_BITS-1:0] seed_sh_q, seed_sh_d;
    logic                 mismatch_q, mismatch_d;

    logic h_fall, v_fall, v_rise;
    logic start_line, in_capture, abort, line_word, last_word;
    logic [SW_W-1:0]      byte_sel;
    logic [7:0]           seed_byte;
    logic [9:0]           dout_d;

    hv_edge_detect u_hv_edge_detect (
        .clk    (clk),
        .H      (H),
        .V      (V),
        .h_fall (h_fall),
        .v_fall (v_fall),
        .v_rise (v_rise)
    );

    // The H_fall cycle already carries word 0, so it is treated as part of the
    // line while the state is still ARMED; pixel_cnt_q is 0 there.
    assign start_line = (state_q == ARMED) && h_fall && !v_rise;
    assign in_capture = (state_q == CAPTURE);
    assign abort      = in_capture && (H || v_rise);
    assign line_word  = start_line || (in_capture && !abort);
    assign last_word  = in_capture && !abort && (pixel_cnt_q == LAST_IDX);

    // Check word i (SEED_WORDS <= i < 2*SEED_WORDS) against byte i-SEED_WORDS,
    // byte 0 being the first word received (MSB end of the shift register).
    assign byte_sel = SW_W'(pixel_cnt_q - SEED_END);

    always_comb begin
        seed_byte = 8'h00;
        for (int i = 0; i < SEED_WORDS; i++) begin
            if (byte_sel == SW_W'(i)) begin
                seed_byte = seed_sh_q[SEED_BITS-1-8*i -: 8];
            end
        end
    end

    always_comb begin
        seed_sh_d  = seed_sh_q;
        mismatch_d = start_line ? 1'b0 : mismatch_q;
        if (line_word) begin
            if (pixel_cnt_q < SEED_END) begin
                seed_sh_d = (seed_sh_q << 8) | SEED_BITS'(bt656_stream_in[9:2]);
            end else if (pixel_cnt_q < CHECK_END) begin
                if (bt656_stream_in[9:2] != seed_byte) begin
                    mismatch_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        dout_d = bt656_stream_in;
        if (BLANK_LINE && line_word) begin
            dout_d = black_word(pixel_cnt_q[0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            pixel_cnt_q      <= '0;
            seed_sh_q        <= '0;
            mismatch_q       <= 1'b0;
            bt656_stream_out <= '0;
            V_out            <= 1'b0;
            seed             <= '0;
            seed_valid       <= 1'b0;
            seed_error       <= 1'b0;
        end else begin
            bt656_stream_out <= dout_d;
            V_out            <= V | line_word;
            seed_sh_q        <= seed_sh_d;
            mismatch_q       <= mismatch_d;
            seed_valid       <= last_word && !mismatch_d;
            seed_error       <= abort || (last_word && mismatch_d);
            if (last_word && !mismatch_d) begin
                seed <= seed_sh_d;
            end

            unique case (state_q)
                IDLE: begin
                    pixel_cnt_q <= '0;
                    if (v_fall) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    pixel_cnt_q <= '0;
                    if (v_rise) begin
                        state_q <= IDLE;
                    end else if (h_fall) begin
                        state_q     <= CAPTURE;
                        pixel_cnt_q <= CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (last_word) begin
                        // Counter saturates at the last index while in DONE.
                        state_q <= DONE;
                    end else begin
                        pixel_cnt_q <= pixel_cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (V) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
